// File: rtl/hazard_if.sv
// hazard_if: pipeline-side signals exchanged with the hazard controller
interface hazard_if #(parameter int CNT_W = 32);
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic ResultSrcE, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic [CNT_W-1:0] StallCount, FlushCount;
  logic MemTimeout;
  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output ResultSrcE, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    input  ForwardAE, ForwardBE, StallCount, FlushCount, MemTimeout
  );
  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  ResultSrcE, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    output ForwardAE, ForwardBE, StallCount, FlushCount, MemTimeout
  );
endinterface

// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush/forward control with memory-wait FSM and perf counters
module hazard_unit #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 256
) (
  input logic clk,
  input logic rst,
  hazard_if.slave bus
);
  typedef enum logic {IDLE, MEM_WAIT} state_t;
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
  localparam logic [WW-1:0] WAIT_SET = WW'(TIMEOUT - 2);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  state_t state, state_nx;
  logic [WW-1:0] wait_cnt;
  logic mem_stall, lw_stall, stall_f, flush_d;
  function automatic logic [1:0] fwd(input logic [4:0] rs);
    return (bus.RegWriteM && bus.RdM != 5'd0 && bus.RdM == rs) ? 2'b10 :
           (bus.RegWriteW && bus.RdW != 5'd0 && bus.RdW == rs) ? 2'b01 : 2'b00;
  endfunction
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  always_comb
    state_nx = (state == IDLE) ? ((bus.MemReqM && !bus.MemReadyM) ? MEM_WAIT : IDLE)
                               : (bus.MemReadyM ? IDLE : MEM_WAIT);
  always_comb begin
    mem_stall = ((state == IDLE) && bus.MemReqM && !bus.MemReadyM) ||
                ((state == MEM_WAIT) && !bus.MemReadyM);
    lw_stall  = bus.ResultSrcE && bus.RdE != 5'd0 && (bus.RdE == bus.Rs1D || bus.RdE == bus.Rs2D);
    stall_f   = !rst && (lw_stall || mem_stall);
    flush_d   = bus.PCSrcE && !mem_stall;
    bus.StallF = stall_f;
    bus.StallD = stall_f;
    bus.StallE = !rst && mem_stall;
    bus.StallM = !rst && mem_stall;
    bus.FlushW = rst || mem_stall;
    bus.FlushD = rst || flush_d;
    bus.FlushE = rst || ((lw_stall || bus.PCSrcE) && !mem_stall);
    bus.ForwardAE = rst ? 2'b00 : fwd(bus.Rs1E);
    bus.ForwardBE = rst ? 2'b00 : fwd(bus.Rs2E);
  end
  // wait counter saturates so a long miss never re-arms the timeout compare
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt       <= '0;
      bus.StallCount <= '0;
      bus.FlushCount <= '0;
      bus.MemTimeout <= 1'b0;
    end else begin
      if (state != MEM_WAIT) wait_cnt <= '0;
      else if (!bus.MemReadyM && wait_cnt != WAIT_LAST) wait_cnt <= wait_cnt + 1'b1;
      if (state == MEM_WAIT && !bus.MemReadyM && wait_cnt == WAIT_SET) bus.MemTimeout <= 1'b1;
      if (stall_f && bus.StallCount != CNT_MAX) bus.StallCount <= bus.StallCount + 1'b1;
      if (flush_d && bus.FlushCount != CNT_MAX) bus.FlushCount <= bus.FlushCount + 1'b1;
    end
  end
endmodule
